// File: rtl/truth_table_pkg.sv
// Shared state encoding, mode constants and parameter checks for the
// programmable truth-table function unit.
package truth_table_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_SWEEP = 2'd3
  } tt_state_e;

  // Table bit meaning: SOP marks minterms (f=1), POS marks maxterms (f=0).
  localparam logic MODE_SOP = 1'b0;
  localparam logic MODE_POS = 1'b1;

  localparam int unsigned N_VARS_MIN = 32'd2;
  localparam int unsigned N_VARS_MAX = 32'd8;

  function automatic logic n_vars_legal(input int unsigned n);
    return (n >= N_VARS_MIN) && (n <= N_VARS_MAX);
  endfunction

endpackage

// File: rtl/truth_table_unit_out_stage.sv
// One-entry output holding register with valid/ready; refill and drain may
// happen in the same cycle so a steady stream runs at full rate.
module tt_out_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         can_push,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         valid_r;
  logic [W-1:0] data_r;

  assign can_push  = ~valid_r | out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Holding register: loads on push, empties when drained without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (push) begin
      valid_r <= 1'b1;
      data_r  <= push_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/truth_table_unit.sv
// Programmable N_VARS-input Boolean function: serial truth-table load,
// handshaked evaluation, and a full-input sweep that counts true outputs.
module truth_table_unit
  import truth_table_pkg::*;
#(
  parameter int unsigned N_VARS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_pos,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_done,
  output logic              table_ok,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_VARS-1:0] in_vars,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_f,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [N_VARS:0]   ones_count
);

  localparam int unsigned   DEPTH    = 2 ** N_VARS;
  localparam logic [N_VARS:0] LAST_IDX = {1'b0, {N_VARS{1'b1}}};
  localparam logic [N_VARS:0] CNT_ONE  = {{N_VARS{1'b0}}, 1'b1};

  if (!n_vars_legal(N_VARS)) begin : g_n_vars_check
    $error("truth_table_unit: N_VARS must lie in 2..8");
  end

  tt_state_e         state_r;
  tt_state_e         state_nx_s;
  logic [DEPTH-1:0]  table_r;
  logic              mode_r;
  logic [N_VARS:0]   cnt_r;
  logic [N_VARS:0]   acc_r;
  logic [N_VARS:0]   ones_count_r;
  logic              cfg_done_r;
  logic              table_ok_r;
  logic              sweep_busy_r;
  logic              sweep_done_r;

  logic              cfg_accept_s;
  logic              beat_s;
  logic              last_beat_s;
  logic              sweep_accept_s;
  logic              sweep_step_s;
  logic              sweep_last_s;
  logic              stage_ready_s;
  logic              out_valid_s;
  logic              req_accept_s;
  logic              eval_f_s;
  logic              sweep_f_s;

  assign eval_f_s     = table_r[in_vars] ^ (mode_r == MODE_POS);
  assign sweep_f_s    = table_r[cnt_r[N_VARS-1:0]] ^ (mode_r == MODE_POS);
  assign in_ready     = (state_r == ST_READY) & stage_ready_s;
  assign req_accept_s = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and control strobes; a pending result blocks reload and sweep.
  always_comb begin
    state_nx_s     = state_r;
    cfg_accept_s   = 1'b0;
    beat_s         = 1'b0;
    last_beat_s    = 1'b0;
    sweep_accept_s = 1'b0;
    sweep_step_s   = 1'b0;
    sweep_last_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) begin
          cfg_accept_s = 1'b1;
          state_nx_s   = ST_LOAD;
        end else begin
          state_nx_s   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cfg_valid) begin
          beat_s = 1'b1;
          if (cnt_r == LAST_IDX) begin
            last_beat_s = 1'b1;
            state_nx_s  = ST_READY;
          end else begin
            state_nx_s  = ST_LOAD;
          end
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_READY: begin
        if (cfg_start && !out_valid_s) begin
          cfg_accept_s   = 1'b1;
          state_nx_s     = ST_LOAD;
        end else if (sweep_start && !out_valid_s) begin
          sweep_accept_s = 1'b1;
          state_nx_s     = ST_SWEEP;
        end else begin
          state_nx_s     = ST_READY;
        end
      end
      ST_SWEEP: begin
        sweep_step_s = 1'b1;
        if (cnt_r == LAST_IDX) begin
          sweep_last_s = 1'b1;
          state_nx_s   = ST_READY;
        end else begin
          state_nx_s   = ST_SWEEP;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Table, shared load/sweep index counter, sweep accumulator and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_r      <= {DEPTH{1'b0}};
      mode_r       <= MODE_SOP;
      cnt_r        <= {(N_VARS+1){1'b0}};
      acc_r        <= {(N_VARS+1){1'b0}};
      ones_count_r <= {(N_VARS+1){1'b0}};
      cfg_done_r   <= 1'b0;
      table_ok_r   <= 1'b0;
      sweep_busy_r <= 1'b0;
      sweep_done_r <= 1'b0;
    end else begin
      cfg_done_r   <= last_beat_s;
      sweep_done_r <= sweep_last_s;
      if (cfg_accept_s) begin
        cnt_r      <= {(N_VARS+1){1'b0}};
        mode_r     <= cfg_pos;
        table_ok_r <= 1'b0;
      end else if (beat_s) begin
        table_r[cnt_r[N_VARS-1:0]] <= cfg_bit;
        cnt_r                      <= cnt_r + CNT_ONE;
        if (last_beat_s) begin
          table_ok_r <= 1'b1;
        end
      end else if (sweep_accept_s) begin
        cnt_r        <= {(N_VARS+1){1'b0}};
        acc_r        <= {(N_VARS+1){1'b0}};
        sweep_busy_r <= 1'b1;
      end else if (sweep_step_s) begin
        cnt_r <= cnt_r + CNT_ONE;
        acc_r <= acc_r + {{N_VARS{1'b0}}, sweep_f_s};
        // The last index is folded in here so the count is final one cycle later.
        if (sweep_last_s) begin
          ones_count_r <= acc_r + {{N_VARS{1'b0}}, sweep_f_s};
          sweep_busy_r <= 1'b0;
        end
      end
    end
  end

  tt_out_stage #(
    .W (1)
  ) u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_accept_s),
    .push_data (eval_f_s),
    .can_push  (stage_ready_s),
    .out_valid (out_valid_s),
    .out_data  (out_f),
    .out_ready (out_ready)
  );

  assign out_valid  = out_valid_s;
  assign cfg_done   = cfg_done_r;
  assign table_ok   = table_ok_r;
  assign sweep_busy = sweep_busy_r;
  assign sweep_done = sweep_done_r;
  assign ones_count = ones_count_r;

endmodule

// File: tb/tb_truth_table_unit.sv
// Directed bench for truth_table_unit (N_VARS=4) with a table-level model
// and a result scoreboard checked on every cycle out_valid is high.
module tb_truth_table_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_pos = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_done;
  logic       table_ok;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_vars = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_f;
  logic       sweep_start = 1'b0;
  logic       sweep_busy;
  logic       sweep_done;
  logic [4:0] ones_count;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;
  logic m_tab [16];
  logic m_mode = 1'b0;
  logic q [$];

  truth_table_unit #(.N_VARS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_pos     (cfg_pos),
    .cfg_valid   (cfg_valid),
    .cfg_bit     (cfg_bit),
    .cfg_done    (cfg_done),
    .table_ok    (table_ok),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vars     (in_vars),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_f       (out_f),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .ones_count  (ones_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_f(input int v);
    return m_tab[v] ^ m_mode;
  endfunction

  function automatic int model_ones();
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(model_f(i));
    return s;
  endfunction

  task automatic set_model(input logic [15:0] tab, input logic pos);
    for (int i = 0; i < 16; i++) m_tab[i] = tab[i];
    m_mode = pos;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a result must match the oldest accepted request while it is shown.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        continue;
      end
      if (out_valid) begin
        check("result_pending", (q.size() > 0), 1);
        if (q.size() > 0) begin
          check("out_f_vs_model", out_f, q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model_f(int'(in_vars)));
    end
  endtask

  task automatic check_reset_vals();
    check("rst_cfg_done", cfg_done, 0);
    check("rst_table_ok", table_ok, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_f", out_f, 0);
    check("rst_sweep_busy", sweep_busy, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_ones_count", ones_count, 0);
  endtask

  // Stalls once mid-load with a stray cfg_start that must not restart the load.
  task automatic load_beats(input logic [15:0] tab);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        cfg_valid = 1'b0;
        cfg_start = 1'b1;
        cfg_pos   = ~m_mode;
        tick();
        cfg_start = 1'b0;
        cfg_pos   = 1'b0;
      end
      cfg_valid = 1'b1;
      cfg_bit   = tab[i];
      if (i == 15) begin
        check("cfg_done_early", cfg_done, 0);
        check("table_ok_in_load", table_ok, 0);
      end
      tick();
    end
    cfg_valid = 1'b0;
    check("cfg_done_pulse", cfg_done, 1);
    check("table_ok_set", table_ok, 1);
    tick();
    check("cfg_done_clear", cfg_done, 0);
  endtask

  task automatic do_load(input logic [15:0] tab, input logic pos);
    cfg_start = 1'b1;
    cfg_pos   = pos;
    tick();
    cfg_start = 1'b0;
    cfg_pos   = 1'b0;
    set_model(tab, pos);
    load_beats(tab);
  endtask

  task automatic eval_lit(input logic [3:0] v, input logic exp);
    int n = 0;
    in_valid = 1'b1;
    in_vars  = v;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("eval_accept_bound", (n < 20), 1);
    tick();
    in_valid = 1'b0;
    check("eval_latency_valid", out_valid, 1);
    check("eval_f_literal", out_f, exp);
    tick();
  endtask

  task automatic sweep(input int exp);
    int n = 0;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    while (sweep_busy && n < 40) begin
      n++;
      tick();
    end
    check("sweep_busy_cycles", n, 16);
    check("sweep_done_pulse", sweep_done, 1);
    check("sweep_busy_low", sweep_busy, 0);
    check("ones_count_literal", ones_count, exp);
    check("ones_count_model", ones_count, model_ones());
    tick();
    check("sweep_done_clear", sweep_done, 0);
  endtask

  initial begin
    int p0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: time limit reached after %0d compared", n_cmp);
        $fatal(1, "watchdog");
      end
    join_none

    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    tick();
    tick();
    rst_n = 1'b1;

    // IDLE ignores requests.
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("idle_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;

    do_load(16'h0001, 1'b0);
    eval_lit(4'd0, 1'b1);
    eval_lit(4'd5, 1'b0);
    sweep(1);

    do_load(16'h0001, 1'b1);
    eval_lit(4'd0, 1'b0);
    eval_lit(4'd15, 1'b1);
    sweep(15);

    do_load(16'hFFFF, 1'b0);
    sweep(16);

    // Backpressure, then a full-rate stream.
    do_load(16'hA5C3, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vars   = 4'd6;
    tick();
    in_vars = 4'd4;
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready_low", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_f_held", out_f, 1);
      tick();
    end
    p0 = n_pop;
    out_ready = 1'b1;
    for (int v = 5; v <= 12; v++) begin
      tick();
      in_vars = 4'(v);
    end
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("bp_drained", n_pop - p0, 10);
    check("bp_queue_empty", q.size(), 0);
    sweep(8);

    // cfg_start beats sweep_start in the same READY cycle.
    cfg_start   = 1'b1;
    sweep_start = 1'b1;
    cfg_pos     = 1'b1;
    tick();
    cfg_start   = 1'b0;
    sweep_start = 1'b0;
    cfg_pos     = 1'b0;
    check("both_no_busy", sweep_busy, 0);
    check("both_table_ok_drop", table_ok, 0);
    check("both_ones_hold", ones_count, 8);
    set_model(16'h0007, 1'b1);
    load_beats(16'h0007);
    check("both_ones_after_load", ones_count, 8);
    eval_lit(4'd0, 1'b0);
    eval_lit(4'd3, 1'b1);
    sweep(13);

    // Reset in the middle of a load.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      tick();
    end
    #2 rst_n = 1'b0;
    cfg_valid = 1'b0;
    #1 check_reset_vals();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 0);
    do_load(16'h8001, 1'b0);
    eval_lit(4'd15, 1'b1);
    eval_lit(4'd7, 1'b0);
    sweep(2);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/truth_table_unit.md
# truth_table_unit

Programmable, parametrised Boolean-function unit for N_VARS-input functions. It replaces per-function hard-wired SOP/POS gate modules with one block that serially loads a 2^N_VARS-bit truth table. The table is interpreted as minterms (SOP) or maxterms (POS). The block then evaluates input vectors over a valid/ready handshake, or sweeps every input combination and reports how many are true. It sits in the lab datapath as the shared function evaluator behind the configuration bus.

## Interface
- N_VARS, default 4, number of function inputs; legal range 2..8; table depth is 2^N_VARS.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  begin table load; accepted only in IDLE or READY with out_valid=0
- cfg_pos  in  1  sampled with accepted cfg_start; 0 = SOP (table bit 1 => f=1), 1 = POS (table bit 1 => f=0)
- cfg_valid  in  1  table bit present this cycle (LOAD only)
- cfg_bit  in  1  table bit; index 0 first, index 2^N_VARS-1 last
- cfg_done  out  1  one-cycle pulse, cycle after last bit accepted
- table_ok  out  1  valid table loaded
- in_valid / in_ready  in/out  1  evaluation request handshake
- in_vars  in  N_VARS  input vector; bit N_VARS-1 is the MSB variable (A)
- out_valid / out_ready  out/in  1  result handshake
- out_f  out  1  function value
- sweep_start  in  1  start sweep; accepted only in READY with out_valid=0
- sweep_busy  out  1  high while sweeping
- sweep_done  out  1  one-cycle pulse when ones_count is final
- ones_count  out  N_VARS+1  number of input vectors with f=1 from last sweep

## Operation
- States: IDLE, LOAD, READY, SWEEP. Reset enters IDLE.
- IDLE: in_ready=0. Accepted cfg_start -> LOAD. The load counter clears and mode <= cfg_pos. Other inputs are ignored.
- LOAD: each cfg_valid writes cfg_bit into table[cnt] and cnt increments. cfg_valid-free cycles stall the load. After bit 2^N_VARS-1 -> READY, with cfg_done pulsed and table_ok=1.
- READY: in_ready = ~out_valid | out_ready. Each accepted request registers out_f = table[in_vars] XOR mode.
- out_valid holds, with out_f stable, until out_ready. Accept and drain in the same cycle is allowed, giving full throughput.
- cfg_start in READY reloads the table: table_ok drops next cycle, and mode is resampled.
- cfg_start is ignored while out_valid=1, in LOAD, or in SWEEP. In LOAD, cfg_start does not restart the load.
- sweep_start in READY -> SWEEP. The index counter and accumulator clear. One index is evaluated per cycle, 0 to 2^N_VARS-1, and the accumulator adds f.
- After the last index, ones_count is updated and sweep_done pulses -> READY. in_ready=0 during SWEEP.
- ones_count holds its value until the next sweep completes. It is not cleared by reload.
- Simultaneous cfg_start and sweep_start in READY: cfg_start wins.
- Counter widths are N_VARS+1 bits, so all-true gives 2^N_VARS with no overflow.

## Timing
- Reset values: cfg_done=0, table_ok=0, in_ready=0, out_valid=0, out_f=0, sweep_busy=0, sweep_done=0, ones_count=0. Table contents and mode are cleared to 0.
- Load: 2^N_VARS accepted beats. cfg_done and table_ok rise in the cycle after the last beat.
- Eval latency: 1 cycle (out_valid high in the cycle after handshake).
- Sweep: sweep_busy rises the cycle after sweep_start and stays high 2^N_VARS cycles. sweep_done pulses and ones_count updates in the following cycle, with sweep_busy low.
- Reset mid-LOAD or mid-SWEEP aborts immediately. All outputs return to their reset values and the partial table is discarded.

## Structure
- Shared package/include truth_table_pkg: state encodings, MODE_SOP/MODE_POS constants, and the N_VARS legal-range check.
- One sub-module, tt_out_stage: the one-entry output register with valid/ready and backpressure. It is reused for the result channel.
- The table is a flat 2^N_VARS-bit register. The lookup is a plain indexed mux, with no RAM macro.

## Test plan
- N_VARS=4, SOP: load 16'h0001 -> cfg_done after 16 beats. in_vars=0 -> out_f=1; in_vars=5 -> out_f=0. Sweep -> ones_count=1.
- POS, same table 16'h0001: in_vars=0 -> out_f=0; in_vars=15 -> out_f=1. Sweep -> ones_count=15 after 16 busy cycles.
- Load 16'hFFFF SOP, then sweep -> ones_count=5'b10000 (16), with no wrap.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_f held. Then out_ready=1 -> one result per cycle, none lost.
- Assert rst_n=0 after 7 load beats -> all outputs go to reset values. A fresh 16-beat load then succeeds.
- cfg_start and sweep_start in the same READY cycle -> LOAD entered, no sweep, ones_count unchanged.
